// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline-side observation signals and the
// controller's stall/flush/forward/mul-div outputs, bundled for one port.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             LoadE;
    logic             PCSrcE;
    logic             MdOpE;
    logic             MdDone;
    logic             MdGo;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             MdTimeout;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    // Pipeline / datapath side
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE, MdOpE, MdDone,
        input  MdGo, ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM, MdTimeout, StallCnt, FlushCnt
    );

    // Hazard controller side
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE, MdOpE, MdDone,
        output MdGo, ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, FlushM, MdTimeout, StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard / sequencing controller for the 5-stage pipeline.
// Forwarding selects, load-use stall, branch flush, and a mul/div
// start/done sequencer with an 8-bit watchdog.
// Optional feature macro: HAZARD_PERF_CNT_EN (saturating stall/flush
// cycle counters; when undefined the counters read as zero).
// All pipeline controls are combinational from inputs and state and are
// forced low while reset is asserted.
module hazard_ctrl #(
    parameter int CNT_W      = 16,
    parameter int MD_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam logic [7:0] WD_LIMIT = 8'(MD_TIMEOUT);

    md_state_e  state_q;
    logic [7:0] wd_q;
    logic       timeout_q;
    logic [7:0] wd_inc_s;

    logic       md_issue_s;
    logic       md_wait_s;
    logic       md_hold_s;
    logic       lw_stall_s;
    logic       stall_f_s;
    logic       flush_d_s;
    logic       flush_e_s;

    // Forward select for one EX source: MEM beats WB, x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        logic [1:0] sel;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign wd_inc_s = wd_q + 8'd1;

    // Hazard detection and pipeline control generation.
    always_comb begin
        md_issue_s = reset && (state_q == ST_IDLE) && hz.MdOpE;
        md_wait_s  = reset && (state_q == ST_BUSY) && !hz.MdDone;
        md_hold_s  = md_issue_s || md_wait_s;
        lw_stall_s = reset && hz.LoadE && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        stall_f_s  = lw_stall_s || md_hold_s;
        flush_d_s  = reset && hz.PCSrcE && !md_hold_s;
        flush_e_s  = reset && (lw_stall_s || hz.PCSrcE) && !md_hold_s;

        hz.MdGo      = md_issue_s;
        hz.StallF    = stall_f_s;
        hz.StallD    = stall_f_s;
        hz.StallE    = md_hold_s;
        hz.FlushM    = md_hold_s;
        hz.FlushD    = flush_d_s;
        hz.FlushE    = flush_e_s;
        hz.MdTimeout = timeout_q;
        if (reset) begin
            hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
            hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
        end else begin
            hz.ForwardAE = 2'b00;
            hz.ForwardBE = 2'b00;
        end
    end

    // Mul/div sequencer FSM with watchdog; a timeout returns to IDLE and sticks the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wd_q      <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hz.MdOpE) begin
                        state_q <= ST_BUSY;
                        wd_q    <= 8'd0;
                    end
                end
                ST_BUSY: begin
                    if (hz.MdDone) begin
                        state_q <= ST_IDLE;
                    end else if (wd_inc_s == WD_LIMIT) begin
                        state_q   <= ST_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_q <= wd_inc_s;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    wd_q    <= 8'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counts of stalled cycles and flushed (D or E) cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (stall_f_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if ((flush_d_s || flush_e_s) && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign hz.StallCnt = stall_cnt_q;
    assign hz.FlushCnt = flush_cnt_q;
`else
    assign hz.StallCnt = {CNT_W{1'b0}};
    assign hz.FlushCnt = {CNT_W{1'b0}};
`endif

endmodule
